axi_lrsc_initiator: RTL
=======================

AXI_LRSC_INITIATOR -- requirements
Module: axi_lrsc_initiator

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 32: AXI and request address width.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 64: AXI and request data width (power of two, >=8).
REQ-003 SHALL have parameter AXI_ID_WIDTH, default 4: AXI ID width.
REQ-004 SHALL have parameter AXI_ID, default 0: ID driven on every AR/AW.
REQ-005 SHALL have the following ports (name, direction, width, meaning):
- clk_i  in  1  clock; all logic rising-edge.
- rst_i  in  1  reset; asynchronous, active-high.
- req_valid_i / req_ready_o  in/out  1  request handshake.
- req_op_i  in  2  00 LR, 01 SC, 10 plain load, 11 plain store.
- req_addr_i  in  AXI_ADDR_WIDTH  byte address.
- req_wdata_i / req_strb_i  in  AXI_DATA_WIDTH / AXI_DATA_WIDTH/8  store data and strobe (SC, store).
- rsp_valid_o / rsp_ready_i  out/in  1  response handshake.
- rsp_rdata_o  out  AXI_DATA_WIDTH  read data (LR, load); 0 for writes.
- rsp_sc_fail_o  out  1  SC not performed.
- rsp_err_o  out  1  bus error, ID mismatch, or no exclusive support.
- mst_ar_addr_o, mst_ar_id_o, mst_ar_lock_o, mst_ar_valid_o out; mst_ar_ready_i in: AXI AR.
- mst_r_data_i, mst_r_resp_i(2), mst_r_id_i, mst_r_last_i, mst_r_valid_i in; mst_r_ready_o out: AXI R.
- mst_aw_addr_o, mst_aw_id_o, mst_aw_lock_o, mst_aw_valid_o out; mst_aw_ready_i in: AXI AW.
- mst_w_data_o, mst_w_strb_o, mst_w_last_o, mst_w_valid_o out; mst_w_ready_i in: AXI W.
- mst_b_resp_i(2), mst_b_id_i, mst_b_valid_i in; mst_b_ready_o out: AXI B.
- mst_ar_len_o/mst_aw_len_o (8), mst_ar_size_o/mst_aw_size_o (3), mst_ar_burst_o/mst_aw_burst_o (2), mst_aw_atop_o (6)  out  constants: len 0, size clog2(AXI_DATA_WIDTH/8), burst INCR, atop 0.

Function
REQ-006 SHALL use FSM states IDLE, AR, R, AWW, B, RSP; one transaction outstanding.
REQ-007 IDLE: req_ready_o=1; on req_valid_i capture op/addr/wdata/strb into registers; go AR (op 00/10) or AWW (op 01/11).
REQ-008 Latency: AR or AW/W valid SHALL assert the cycle after request acceptance, driven from registers only.
REQ-009 ar_lock_o/aw_lock_o SHALL be 1 for LR/SC, 0 for plain ops; addr and id stable while valid is high.
REQ-010 AR: hold ar_valid until ar_ready, then R; R: r_ready=1, capture data/resp/id on r_valid, then RSP.
REQ-011 AWW: assert aw_valid and w_valid together (w_last=1); track aw_done/w_done independently; drop each valid after its handshake; go B when both done (same-cycle completion allowed).
REQ-012 B: b_ready=1; capture resp/id on b_valid, then RSP.
REQ-013 RSP: rsp_valid_o=1, outputs stable until rsp_ready_i; then IDLE. No new request accepted before that cycle.
REQ-014 LR result: EXOKAY(01) -> err 0; OKAY(00) -> err 1 (no exclusive support); resp[1]=1 -> err 1; sc_fail 0.
REQ-015 SC result: EXOKAY -> sc_fail 0, err 0; OKAY -> sc_fail 1, err 0; resp[1]=1 -> sc_fail 1, err 1.
REQ-016 Plain ops: resp[1]=1 -> err 1, else err 0; EXOKAY on plain op -> err 1; sc_fail 0.
REQ-017 r_id/b_id != AXI_ID SHALL set err 1 (and sc_fail 1 for SC); response still consumed.
REQ-018 r_last=0 SHALL set err 1; beat still consumed, transaction ends.

Reset
REQ-019 While rst_i=1 SHALL force IDLE; all valid/ready outputs 0 except req_ready_o=0; rsp_* and address/data registers 0.
REQ-020 Reset assertion mid-transaction SHALL drop all valids asynchronously, without completing or reporting the transaction; req_ready_o=1 in the first cycle after release.

Verification
REQ-021 LR 0x1000, ar_ready immediate, R data 0xDEAD, resp 01 -> AR lock 1, cycle +1; rsp rdata 0xDEAD, err 0, sc_fail 0.
REQ-022 SC 0x1000, data 0x55, strb 0xFF, B resp 01 -> AW/W lock 1, w_last 1; rsp sc_fail 0, err 0.
REQ-023 SC, B resp 00 -> sc_fail 1, err 0; SC, B resp 10 -> sc_fail 1, err 1.
REQ-024 Store, w_ready 3 cycles before aw_ready -> w_valid drops after its handshake; aw_valid holds; exactly one B awaited; err 0.
REQ-025 LR, R resp 00 -> err 1; load, r_id=AXI_ID+1 -> err 1.
REQ-026 rst_i pulse while in R or B -> all valids 0 immediately; no rsp_valid; next LR completes normally.

Source files
------------

// File: rtl/axi_lrsc_initiator.sv
// rtl/axi_lrsc_initiator.sv - single-outstanding AXI initiator for LR/SC and plain load/store
module axi_lrsc_initiator #(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int AXI_ID_WIDTH   = 4,
   parameter int AXI_ID         = 0
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        req_valid_i,
   output logic                        req_ready_o,
   input  logic [1:0]                  req_op_i,
   input  logic [AXI_ADDR_WIDTH-1:0]   req_addr_i,
   input  logic [AXI_DATA_WIDTH-1:0]   req_wdata_i,
   input  logic [AXI_DATA_WIDTH/8-1:0] req_strb_i,
   output logic                        rsp_valid_o,
   input  logic                        rsp_ready_i,
   output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata_o,
   output logic                        rsp_sc_fail_o,
   output logic                        rsp_err_o,
   output logic [AXI_ADDR_WIDTH-1:0]   mst_ar_addr_o,
   output logic [AXI_ID_WIDTH-1:0]     mst_ar_id_o,
   output logic                        mst_ar_lock_o,
   output logic                        mst_ar_valid_o,
   input  logic                        mst_ar_ready_i,
   output logic [7:0]                  mst_ar_len_o,
   output logic [2:0]                  mst_ar_size_o,
   output logic [1:0]                  mst_ar_burst_o,
   input  logic [AXI_DATA_WIDTH-1:0]   mst_r_data_i,
   input  logic [1:0]                  mst_r_resp_i,
   input  logic [AXI_ID_WIDTH-1:0]     mst_r_id_i,
   input  logic                        mst_r_last_i,
   input  logic                        mst_r_valid_i,
   output logic                        mst_r_ready_o,
   output logic [AXI_ADDR_WIDTH-1:0]   mst_aw_addr_o,
   output logic [AXI_ID_WIDTH-1:0]     mst_aw_id_o,
   output logic                        mst_aw_lock_o,
   output logic                        mst_aw_valid_o,
   input  logic                        mst_aw_ready_i,
   output logic [7:0]                  mst_aw_len_o,
   output logic [2:0]                  mst_aw_size_o,
   output logic [1:0]                  mst_aw_burst_o,
   output logic [5:0]                  mst_aw_atop_o,
   output logic [AXI_DATA_WIDTH-1:0]   mst_w_data_o,
   output logic [AXI_DATA_WIDTH/8-1:0] mst_w_strb_o,
   output logic                        mst_w_last_o,
   output logic                        mst_w_valid_o,
   input  logic                        mst_w_ready_i,
   input  logic [1:0]                  mst_b_resp_i,
   input  logic [AXI_ID_WIDTH-1:0]     mst_b_id_i,
   input  logic                        mst_b_valid_i,
   output logic                        mst_b_ready_o
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_AR   = 3'd1;
   localparam logic [2:0] S_R    = 3'd2;
   localparam logic [2:0] S_AWW  = 3'd3;
   localparam logic [2:0] S_B    = 3'd4;
   localparam logic [2:0] S_RSP  = 3'd5;

   localparam logic [AXI_ID_WIDTH-1:0] ID_C   = AXI_ID[AXI_ID_WIDTH-1:0];
   localparam logic [2:0]              SIZE_C = 3'($clog2(AXI_DATA_WIDTH/8));

   logic [2:0]                  r_state;
   logic [1:0]                  r_op;
   logic [AXI_ADDR_WIDTH-1:0]   r_addr;
   logic [AXI_DATA_WIDTH-1:0]   r_wdata;
   logic [AXI_DATA_WIDTH/8-1:0] r_strb;
   logic                        r_aw_done;
   logic                        r_w_done;
   logic [AXI_DATA_WIDTH-1:0]   r_rsp_rdata;
   logic                        r_rsp_fail;
   logic                        r_rsp_err;

   // op[0] selects the write path, op[1]=0 marks an exclusive access
   logic w_excl;
   logic w_aw_hs;
   logic w_w_hs;
   logic w_rid_bad;
   logic w_bid_bad;

   assign w_excl    = ~r_op[1];
   assign w_aw_hs   = mst_aw_valid_o & mst_aw_ready_i;
   assign w_w_hs    = mst_w_valid_o & mst_w_ready_i;
   assign w_rid_bad = (mst_r_id_i != ID_C);
   assign w_bid_bad = (mst_b_id_i != ID_C);

   assign req_ready_o    = (r_state == S_IDLE) & ~rst_i;
   assign rsp_valid_o    = (r_state == S_RSP);
   assign rsp_rdata_o    = r_rsp_rdata;
   assign rsp_sc_fail_o  = r_rsp_fail;
   assign rsp_err_o      = r_rsp_err;

   assign mst_ar_addr_o  = r_addr;
   assign mst_ar_id_o    = ID_C;
   assign mst_ar_lock_o  = w_excl;
   assign mst_ar_valid_o = (r_state == S_AR);
   assign mst_ar_len_o   = 8'd0;
   assign mst_ar_size_o  = SIZE_C;
   assign mst_ar_burst_o = 2'b01;
   assign mst_r_ready_o  = (r_state == S_R);

   assign mst_aw_addr_o  = r_addr;
   assign mst_aw_id_o    = ID_C;
   assign mst_aw_lock_o  = w_excl;
   assign mst_aw_valid_o = (r_state == S_AWW) & ~r_aw_done;
   assign mst_aw_len_o   = 8'd0;
   assign mst_aw_size_o  = SIZE_C;
   assign mst_aw_burst_o = 2'b01;
   assign mst_aw_atop_o  = 6'd0;
   assign mst_w_data_o   = r_wdata;
   assign mst_w_strb_o   = r_strb;
   assign mst_w_last_o   = 1'b1;
   assign mst_w_valid_o  = (r_state == S_AWW) & ~r_w_done;
   assign mst_b_ready_o  = (r_state == S_B);

   // transaction sequencer: capture request, run one AXI transaction, hold the response
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state     <= S_IDLE;
         r_op        <= 2'b00;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_strb      <= '0;
         r_aw_done   <= 1'b0;
         r_w_done    <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_fail  <= 1'b0;
         r_rsp_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid_i) begin
                  r_op      <= req_op_i;
                  r_addr    <= req_addr_i;
                  r_wdata   <= req_wdata_i;
                  r_strb    <= req_strb_i;
                  r_aw_done <= 1'b0;
                  r_w_done  <= 1'b0;
                  r_state   <= req_op_i[0] ? S_AWW : S_AR;
               end
            end
            S_AR: begin
               if (mst_ar_ready_i) r_state <= S_R;
            end
            S_R: begin
               if (mst_r_valid_i) begin
                  // exclusive reads must see EXOKAY, plain reads must see OKAY
                  r_rsp_rdata <= mst_r_data_i;
                  r_rsp_fail  <= 1'b0;
                  r_rsp_err   <= (mst_r_resp_i != (w_excl ? 2'b01 : 2'b00))
                                 | w_rid_bad | ~mst_r_last_i;
                  r_state     <= S_RSP;
               end
            end
            S_AWW: begin
               if (w_aw_hs) r_aw_done <= 1'b1;
               if (w_w_hs)  r_w_done  <= 1'b1;
               if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) r_state <= S_B;
            end
            S_B: begin
               if (mst_b_valid_i) begin
                  r_rsp_rdata <= '0;
                  if (w_excl) begin
                     // OKAY on SC means the reservation was lost, not a bus fault
                     r_rsp_fail <= (mst_b_resp_i != 2'b01) | w_bid_bad;
                     r_rsp_err  <= mst_b_resp_i[1] | w_bid_bad;
                  end else begin
                     r_rsp_fail <= 1'b0;
                     r_rsp_err  <= (mst_b_resp_i != 2'b00) | w_bid_bad;
                  end
                  r_state <= S_RSP;
               end
            end
            S_RSP: begin
               if (rsp_ready_i) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
